// File: rtl/femto_spi_loader.sv
// SPI-slave boot loader for the femto core: streams little-endian words into a
// valid/ready write port, reports status, and controls the core run/halt level.
module femto_spi_loader #(
    parameter int ADDR_W       = 16,
    parameter int MIN_SCLK_DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_run,
    output logic              overflow
);

    if (MIN_SCLK_DIV < 4) begin : g_div_check
        $error("MIN_SCLK_DIV is too small for the 2-flop synchronizers");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA, S_STATUS, S_IGNORE
    } state_t;

    typedef enum logic [1:0] {ACT_NONE, ACT_RUN, ACT_HALT} act_t;

    state_t state, state_nx;
    act_t   act;

    logic              sclk_m, sclk_s, sclk_d;
    logic              cs_m, cs_s;
    logic              mosi_m, mosi_s;
    logic [1:0]        sync_ok;
    logic              cs_hi_seen;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        addr_hi;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic              word_pend;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        stat_sh;
    logic              stat_skip;
    logic              frag;

    logic       sclk_rise, sclk_fall, cs_fall, cs_rise, shift_en, byte_done;
    logic       status_end, frag_set;
    logic [7:0] rx_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_m     <= 1'b0;
            sclk_s     <= 1'b0;
            sclk_d     <= 1'b0;
            cs_m       <= 1'b1;
            cs_s       <= 1'b1;
            mosi_m     <= 1'b0;
            mosi_s     <= 1'b0;
            sync_ok    <= '0;
            cs_hi_seen <= 1'b0;
        end else begin
            sclk_m     <= spi_sclk;
            sclk_s     <= sclk_m;
            sclk_d     <= sclk_s;
            cs_m       <= spi_cs_n;
            cs_s       <= cs_m;
            mosi_m     <= spi_mosi;
            mosi_s     <= mosi_m;
            sync_ok    <= {sync_ok[0], 1'b1};
            // A transaction already open across reset release must not look like a new one
            if (sync_ok[1] && cs_s)
                cs_hi_seen <= 1'b1;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_d;
    assign sclk_fall  = ~sclk_s & sclk_d;
    assign cs_fall    = (state == S_IDLE) && !cs_s && cs_hi_seen;
    assign cs_rise    = (state != S_IDLE) && cs_s;
    assign shift_en   = (state != S_IDLE) && !cs_s && sclk_rise;
    assign rx_byte    = {shreg[6:0], mosi_s};
    assign byte_done  = shift_en && (bit_cnt == 3'd7);
    assign status_end = cs_rise && (state == S_STATUS);
    assign frag_set   = cs_rise && (state == S_DATA) && (byte_cnt != 2'd0);
    assign spi_miso   = (state == S_STATUS) ? stat_sh[7] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == S_IDLE) begin
            if (cs_fall)
                state_nx = S_CMD;
        end else if (cs_rise) begin
            state_nx = S_IDLE;
        end else if (byte_done) begin
            case (state)
                S_CMD: begin
                    if (rx_byte == 8'h02)
                        state_nx = S_ADDR_HI;
                    else if (rx_byte == 8'h05)
                        state_nx = S_STATUS;
                    else
                        state_nx = S_IGNORE;
                end
                S_ADDR_HI: state_nx = S_ADDR_LO;
                S_ADDR_LO: state_nx = S_DATA;
                default:   state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            addr_hi   <= '0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            word_pend <= 1'b0;
            addr      <= '0;
            act       <= ACT_NONE;
            stat_sh   <= '0;
            stat_skip <= 1'b0;
            frag      <= 1'b0;
            core_run  <= 1'b0;
            overflow  <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            if (state == S_IDLE || cs_rise)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;

            if (shift_en)
                shreg <= rx_byte;

            word_pend <= byte_done && (state == S_DATA) && (byte_cnt == 2'd3);

            if (byte_done) begin
                case (state)
                    S_CMD: begin
                        if (rx_byte == 8'h01)
                            act <= ACT_RUN;
                        else if (rx_byte == 8'h03)
                            act <= ACT_HALT;
                        else
                            act <= ACT_NONE;
                        if (rx_byte == 8'h05) begin
                            stat_sh   <= {4'b0, core_run, frag, overflow, wr_valid};
                            stat_skip <= 1'b1;
                        end
                    end
                    S_ADDR_HI: addr_hi <= rx_byte;
                    S_ADDR_LO: begin
                        addr     <= ADDR_W'({addr_hi, rx_byte[7:2], 2'b00});
                        byte_cnt <= '0;
                    end
                    S_DATA: begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end

            // The falling edge that closes the command byte must not consume the MSB
            if (state == S_STATUS && !cs_s && sclk_fall) begin
                if (stat_skip)
                    stat_skip <= 1'b0;
                else
                    stat_sh <= {stat_sh[6:0], 1'b0};
            end

            if (cs_rise && state == S_IGNORE) begin
                if (act == ACT_RUN)
                    core_run <= 1'b1;
                else if (act == ACT_HALT)
                    core_run <= 1'b0;
            end

            if (status_end)
                frag <= 1'b0;
            if (frag_set)
                frag <= 1'b1;

            if (status_end)
                overflow <= 1'b0;

            if (word_pend) begin
                addr <= addr + ADDR_W'(4);
                if (!wr_valid || wr_ready) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= addr;
                    wr_data  <= word_buf;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_femto_spi_loader.sv
// Scoreboard bench for femto_spi_loader: an SPI host model drives transactions,
// expected words are queued up front and popped as the write port transfers.
module tb_femto_spi_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_run, overflow;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  xfer_cnt = 0;

    logic        hold_prev = 1'b0;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;

    femto_spi_loader #(.ADDR_W(16), .MIN_SCLK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_run(core_run), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Write-port monitor: transfers are popped against the scoreboard, held words must not move
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (hold_prev) begin
                n_tests++;
                if (wr_valid !== 1'b1 || wr_addr !== prev_addr || wr_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%b a=%h d=%h, want v=1 a=%h d=%h",
                             wr_valid, wr_addr, wr_data, prev_addr, prev_data);
                end
            end
            if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
                xfer_cnt++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_xfer: got a=%h d=%h, want no transfer", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        n_fail++;
                        $display("FAIL xfer: got a=%h d=%h, want a=%h d=%h", wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
            hold_prev = (wr_valid === 1'b1) && (wr_ready === 1'b0);
            prev_addr = wr_addr;
            prev_data = wr_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 wr_ready = v;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        wait_cycles(2);
    endtask

    task automatic spi_begin();
        spi_sclk = 1'b0;
        spi_cs_n = 1'b0;
        #100;
    endtask

    task automatic spi_end();
        #50 spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            #50 rx[i] = spi_miso;
            spi_sclk = 1'b1;
            #50 spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx);
        logic [7:0] rx;
        spi_bits(tx, 8, rx);
    endtask

    task automatic spi_status(output logic [7:0] st);
        spi_begin();
        spi_byte(8'h05);
        spi_bits(8'h00, 8, st);
        spi_end();
    endtask

    task automatic spi_cmd(input logic [7:0] cmd);
        spi_begin();
        spi_byte(cmd);
        spi_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; wr_ready = 1'b0;
        #23;
        n_tests++;
        if ({wr_valid, wr_addr, wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_wr: got v=%b a=%h d=%h, want all 0", wr_valid, wr_addr, wr_data);
        end
        n_tests++;
        if ({core_run, overflow, spi_miso} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got run=%b ovf=%b miso=%b, want 000", core_run, overflow, spi_miso);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(8);
    endtask

    task automatic test_simple_write();
        int x0;
        x0 = xfer_cnt;
        set_ready(1'b1);
        sb.push_back('{addr: 16'h0100, data: 32'h44332211});
        spi_begin();
        spi_byte(8'h02); spi_byte(8'h01); spi_byte(8'h00);
        spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44);
        spi_end();
        wait_drain(200);
        n_tests++;
        if (xfer_cnt - x0 != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL simple_count: got %0d transfers (%0d left), want 1", xfer_cnt - x0, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int x0;
        logic [7:0] st;
        set_ready(1'b0);
        sb.push_back('{addr: 16'h0000, data: 32'h04030201});
        spi_begin();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00);
        for (int b = 1; b <= 12; b++) spi_byte(8'(b));
        spi_end();
        wait_cycles(10);
        n_tests++;
        if (wr_valid !== 1'b1 || wr_addr !== 16'h0000 || wr_data !== 32'h04030201) begin
            n_fail++;
            $display("FAIL bp_held: got v=%b a=%h d=%h, want v=1 a=0000 d=04030201", wr_valid, wr_addr, wr_data);
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overflow: got %b, want 1", overflow);
        end
        x0 = xfer_cnt;
        set_ready(1'b1);
        wait_cycles(10);
        n_tests++;
        if (xfer_cnt - x0 != 1 || wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d transfers v=%b, want 1 transfer v=0", xfer_cnt - x0, wr_valid);
        end
        spi_status(st);
        n_tests++;
        if (st !== 8'h02) begin
            n_fail++;
            $display("FAIL bp_status: got %h, want 02", st);
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ovf_clear: got %b, want 0", overflow);
        end
    endtask

    task automatic test_wrap();
        int x0;
        x0 = xfer_cnt;
        sb.push_back('{addr: 16'hFFFC, data: 32'hA3A2A1A0});
        sb.push_back('{addr: 16'h0000, data: 32'hA7A6A5A4});
        spi_begin();
        spi_byte(8'h02); spi_byte(8'hFF); spi_byte(8'hFE);
        for (int b = 0; b < 8; b++) spi_byte(8'hA0 + 8'(b));
        spi_end();
        wait_drain(200);
        n_tests++;
        if (xfer_cnt - x0 != 2 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d transfers (%0d left), want 2", xfer_cnt - x0, sb.size());
        end
    endtask

    task automatic test_run_frag();
        logic [7:0] st, rx;
        spi_begin();
        spi_byte(8'h01);
        #50;
        n_tests++;
        if (core_run !== 1'b0) begin
            n_fail++;
            $display("FAIL run_early: got %b, want 0 before cs_n rise", core_run);
        end
        spi_end();
        n_tests++;
        if (core_run !== 1'b1) begin
            n_fail++;
            $display("FAIL run_set: got %b, want 1", core_run);
        end
        sb.push_back('{addr: 16'h0200, data: 32'h54535251});
        spi_begin();
        spi_byte(8'h02); spi_byte(8'h02); spi_byte(8'h00);
        for (int b = 0; b < 6; b++) spi_byte(8'h51 + 8'(b));
        spi_end();
        wait_drain(200);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL frag_word: got %0d words outstanding, want 0", sb.size());
        end
        spi_status(st);
        n_tests++;
        if (st !== 8'h0C) begin
            n_fail++;
            $display("FAIL frag_status: got %h, want 0C", st);
        end
        spi_cmd(8'h03);
        n_tests++;
        if (core_run !== 1'b0) begin
            n_fail++;
            $display("FAIL halt: got %b, want 0", core_run);
        end
        spi_begin();
        spi_bits(8'h01, 5, rx);
        spi_end();
        spi_status(st);
        n_tests++;
        if (st !== 8'h00 || core_run !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cmd: got status=%h run=%b, want 00 run=0", st, core_run);
        end
    endtask

    task automatic test_reset_mid_write();
        int x0;
        spi_cmd(8'h01);
        x0 = xfer_cnt;
        spi_begin();
        spi_byte(8'h02); spi_byte(8'h03); spi_byte(8'h00);
        spi_byte(8'hAA); spi_byte(8'hBB);
        #23 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({wr_valid, wr_addr, wr_data} !== '0 || {core_run, overflow, spi_miso} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b a=%h d=%h run=%b ovf=%b miso=%b, want all 0",
                     wr_valid, wr_addr, wr_data, core_run, overflow, spi_miso);
        end
        #36 rst_n = 1'b1;
        #100;
        spi_byte(8'hCC); spi_byte(8'hDD);
        spi_byte(8'hEE); spi_byte(8'hFF);
        spi_end();
        wait_cycles(20);
        n_tests++;
        if (xfer_cnt - x0 != 0 || wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got %0d transfers v=%b, want 0 transfers v=0", xfer_cnt - x0, wr_valid);
        end
    endtask

    task automatic test_back_to_back();
        int x0;
        x0 = xfer_cnt;
        sb.push_back('{addr: 16'h0500, data: 32'hDDCCBBAA});
        sb.push_back('{addr: 16'h0504, data: 32'h87654321});
        spi_begin();
        spi_byte(8'h02); spi_byte(8'h05); spi_byte(8'h01);
        spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC); spi_byte(8'hDD);
        spi_byte(8'h21); spi_byte(8'h43); spi_byte(8'h65); spi_byte(8'h87);
        spi_end();
        wait_drain(200);
        n_tests++;
        if (xfer_cnt - x0 != 2 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d transfers (%0d left), want 2", xfer_cnt - x0, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_simple_write();
        test_backpressure();
        test_wrap();
        test_run_frag();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at 3ms, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
